// File: rtl/vec_lsu_ldst_if.sv
// -----------------------------------------------------------------------------
// vec_lsu_ldst_if
// Memory-side port of the vector load/store unit: one word-wide req/ack channel.
//   master (LSU)    : drives lsu2mem_addr, ld_req, st_req, lsu2mem_data,
//                     lsu2mem_wmask; receives mem2lsu_data, mem_ack
//   slave  (memory) : the mirror image
// A request is held stable until the memory raises mem_ack. For loads, read
// data is valid in that same ack cycle.
// -----------------------------------------------------------------------------
interface vec_lsu_ldst_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] lsu2mem_addr;
  logic            ld_req;
  logic            st_req;
  logic [31:0]     lsu2mem_data;
  logic [3:0]      lsu2mem_wmask;
  logic [31:0]     mem2lsu_data;
  logic            mem_ack;

  modport master (
    output lsu2mem_addr, ld_req, st_req, lsu2mem_data, lsu2mem_wmask,
    input  mem2lsu_data, mem_ack
  );

  modport slave (
    input  lsu2mem_addr, ld_req, st_req, lsu2mem_data, lsu2mem_wmask,
    output mem2lsu_data, mem_ack
  );
endinterface

// File: rtl/vec_lsu_ldst.sv
// -----------------------------------------------------------------------------
// vec_lsu_ldst
// Unit-stride / constant-stride vector load/store unit for 8/16/32-bit
// elements. One element is transferred per acknowledged memory request.
// Misaligned addresses and unsupported element widths stop the instruction
// and raise lsu_err instead of issuing the access.
// Ports:
//   clk, n_rst        clock, asynchronous active-low reset
//   rs1_data          base byte address
//   rs2_data          byte stride (used when stride_sel = 0)
//   vlmax, sew        requested element count, element width in bits
//   stride_sel        1 = unit stride (sew/8), 0 = rs2_data
//   ld_inst, st_inst  start pulses (load wins when both are set)
//   vs3_data          store source vector
//   mem               memory req/ack port (master side)
//   vd_data           loaded vector, tail elements zero
//   is_loaded/stored  one-cycle completion pulses
//   busy, lsu_err     instruction in flight, sticky error flag
// -----------------------------------------------------------------------------
module vec_lsu_ldst #(
  parameter int XLEN     = 32,
  parameter int VLEN     = 512,
  parameter int MAX_VLEN = 4096
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic [XLEN-1:0]     rs1_data,
  input  logic [XLEN-1:0]     rs2_data,
  input  logic [9:0]          vlmax,
  input  logic [6:0]          sew,
  input  logic                stride_sel,
  input  logic                ld_inst,
  input  logic                st_inst,
  input  logic [MAX_VLEN-1:0] vs3_data,
  vec_lsu_ldst_if.master      mem,
  output logic [MAX_VLEN-1:0] vd_data,
  output logic                is_loaded,
  output logic                is_stored,
  output logic                busy,
  output logic                lsu_err
);

  // A register group is a whole number of vector registers.
  if (MAX_VLEN % VLEN != 0) begin : g_bad_cfg
    $error("MAX_VLEN must be a multiple of VLEN");
  end

  // Element counter must hold both vlmax (10 bits) and MAX_VLEN/8.
  localparam int CNT_W = 11;
  localparam int BIT_W = $clog2(MAX_VLEN);

  typedef enum logic [1:0] {IDLE, LD_REQ, ST_REQ, DONE} state_e;

  state_e              state_q,  state_d;
  logic [CNT_W-1:0]    index_q,  index_d;
  logic [CNT_W-1:0]    n_q,      n_d;
  logic [XLEN-1:0]     addr_q,   addr_d;
  logic [XLEN-1:0]     stride_q, stride_d;
  logic [6:0]          sew_q,    sew_d;
  logic                is_ld_q,  is_ld_d;
  logic [MAX_VLEN-1:0] vs3_q,    vs3_d;
  logic [MAX_VLEN-1:0] vd_q,     vd_d;
  logic                err_q,    err_d;
  logic                ld_req_q, ld_req_d;
  logic                st_req_q, st_req_d;
  logic [31:0]         wdata_q,  wdata_d;
  logic [3:0]          wmask_q,  wmask_d;
  logic                is_loaded_q, is_loaded_d;
  logic                is_stored_q, is_stored_d;

  logic [31:0]         rdata_sh;
  logic [BIT_W-1:0]    elem_base;

  // N = min(vlmax, MAX_VLEN/sew). For an unsupported sew the cap is vlmax,
  // so a non-zero count still reaches the alignment check and flags lsu_err.
  function automatic logic [CNT_W-1:0] eff_count(input logic [9:0] vl,
                                                 input logic [6:0] s);
    logic [CNT_W-1:0] cap;
    case (s)
      7'd8:    cap = CNT_W'(MAX_VLEN / 8);
      7'd16:   cap = CNT_W'(MAX_VLEN / 16);
      7'd32:   cap = CNT_W'(MAX_VLEN / 32);
      default: cap = CNT_W'(vl);
    endcase
    return (CNT_W'(vl) < cap) ? CNT_W'(vl) : cap;
  endfunction

  function automatic logic aligned(input logic [6:0] s, input logic [1:0] a_lo);
    case (s)
      7'd8:    return 1'b1;
      7'd16:   return ~a_lo[0];
      7'd32:   return (a_lo == 2'b00);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input logic [6:0] s, input logic [1:0] a_lo);
    case (s)
      7'd8:    return 4'b0001 << a_lo;
      7'd16:   return a_lo[1] ? 4'b1100 : 4'b0011;
      7'd32:   return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] store_elem(input logic [MAX_VLEN-1:0] v,
                                             input logic [6:0]          s,
                                             input logic [CNT_W-1:0]    idx);
    logic [BIT_W-1:0] b;
    b = BIT_W'(idx);
    case (s)
      7'd8:    return {24'b0, v[(b << 3) +: 8]};
      7'd16:   return {16'b0, v[(b << 4) +: 16]};
      7'd32:   return v[(b << 5) +: 32];
      default: return 32'b0;
    endcase
  endfunction

  always_comb begin
    // NOTE: every variable gets its default before any branch so that no path
    // leaves a value unassigned, which would infer a latch.
    state_d   = state_q;
    index_d   = index_q;
    n_d       = n_q;
    addr_d    = addr_q;
    stride_d  = stride_q;
    sew_d     = sew_q;
    is_ld_d   = is_ld_q;
    vs3_d     = vs3_q;
    vd_d      = vd_q;
    err_d     = err_q;
    rdata_sh  = mem.mem2lsu_data >> {addr_q[1:0], 3'b000};
    elem_base = BIT_W'(index_q);

    case (state_q)
      IDLE: begin
        if (ld_inst || st_inst) begin
          is_ld_d  = ld_inst;
          sew_d    = sew;
          n_d      = eff_count(vlmax, sew);
          stride_d = stride_sel ? XLEN'(sew >> 3) : rs2_data;
          vs3_d    = vs3_data;
          err_d    = 1'b0;
          index_d  = '0;
          addr_d   = rs1_data;
          if (ld_inst) vd_d = '0;
          if (n_d == '0) begin
            state_d = DONE;
          end else if (!aligned(sew, rs1_data[1:0])) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = ld_inst ? LD_REQ : ST_REQ;
          end
        end
      end

      LD_REQ, ST_REQ: begin
        if (mem.mem_ack) begin
          if (state_q == LD_REQ) begin
            case (sew_q)
              7'd8:    vd_d[(elem_base << 3) +: 8]  = rdata_sh[7:0];
              7'd16:   vd_d[(elem_base << 4) +: 16] = rdata_sh[15:0];
              default: vd_d[(elem_base << 5) +: 32] = rdata_sh;
            endcase
          end
          if (index_q == n_q - 1'b1) begin
            state_d = DONE;
          end else begin
            index_d = index_q + 1'b1;
            addr_d  = addr_q + stride_q;
            // Next element is checked before its request is ever raised.
            if (!aligned(sew_q, addr_d[1:0])) begin
              err_d   = 1'b1;
              state_d = DONE;
            end
          end
        end
      end

      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Request outputs are registered images of the next state, so mem_ack
    // never reaches them combinationally.
    ld_req_d    = (state_d == LD_REQ);
    st_req_d    = (state_d == ST_REQ);
    is_loaded_d = (state_d == DONE) &&  is_ld_d;
    is_stored_d = (state_d == DONE) && !is_ld_d;
    if (st_req_d) begin
      wmask_d = lane_mask(sew_d, addr_d[1:0]);
      wdata_d = store_elem(vs3_d, sew_d, index_d) << {addr_d[1:0], 3'b000};
    end else begin
      wmask_d = 4'b0000;
      wdata_d = 32'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  // NOTE: vd_q and vs3_q are plain flop registers rather than RAM, so they
  // take the asynchronous reset like all other state.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      index_q     <= '0;
      n_q         <= '0;
      addr_q      <= '0;
      stride_q    <= '0;
      sew_q       <= '0;
      is_ld_q     <= 1'b0;
      vs3_q       <= '0;
      vd_q        <= '0;
      err_q       <= 1'b0;
      ld_req_q    <= 1'b0;
      st_req_q    <= 1'b0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      is_loaded_q <= 1'b0;
      is_stored_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      index_q     <= index_d;
      n_q         <= n_d;
      addr_q      <= addr_d;
      stride_q    <= stride_d;
      sew_q       <= sew_d;
      is_ld_q     <= is_ld_d;
      vs3_q       <= vs3_d;
      vd_q        <= vd_d;
      err_q       <= err_d;
      ld_req_q    <= ld_req_d;
      st_req_q    <= st_req_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
      is_loaded_q <= is_loaded_d;
      is_stored_q <= is_stored_d;
    end
  end

  assign mem.lsu2mem_addr  = {addr_q[XLEN-1:2], 2'b00};
  assign mem.ld_req        = ld_req_q;
  assign mem.st_req        = st_req_q;
  assign mem.lsu2mem_data  = wdata_q;
  assign mem.lsu2mem_wmask = wmask_q;
  assign vd_data           = vd_q;
  assign is_loaded         = is_loaded_q;
  assign is_stored         = is_stored_q;
  assign busy              = (state_q != IDLE);
  assign lsu_err           = err_q;

endmodule

// File: tb/tb_vec_lsu_ldst.sv
// -----------------------------------------------------------------------------
// tb_vec_lsu_ldst
// Directed bench for vec_lsu_ldst. A behavioural memory answers requests with
// zero or random 0-3 wait states, logs every accepted transfer and watches
// that requests stay stable while waiting. Expected values come from the
// memory's address-to-data function and hand-computed address sequences.
// -----------------------------------------------------------------------------
module tb_vec_lsu_ldst;

  localparam int XLEN     = 32;
  localparam int MAX_VLEN = 4096;

  typedef struct {
    bit          is_st;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } xact_t;

  logic                clk = 1'b0;
  logic                n_rst;
  logic [XLEN-1:0]     rs1_data, rs2_data;
  logic [9:0]          vlmax;
  logic [6:0]          sew;
  logic                stride_sel, ld_inst, st_inst;
  logic [MAX_VLEN-1:0] vs3_data;
  logic [MAX_VLEN-1:0] vd_data;
  logic                is_loaded, is_stored, busy, lsu_err;

  vec_lsu_ldst_if #(.XLEN(XLEN)) mem_if ();

  vec_lsu_ldst #(.XLEN(XLEN), .VLEN(512), .MAX_VLEN(MAX_VLEN)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data),
    .vlmax      (vlmax),
    .sew        (sew),
    .stride_sel (stride_sel),
    .ld_inst    (ld_inst),
    .st_inst    (st_inst),
    .vs3_data   (vs3_data),
    .mem        (mem_if),
    .vd_data    (vd_data),
    .is_loaded  (is_loaded),
    .is_stored  (is_stored),
    .busy       (busy),
    .lsu_err    (lsu_err)
  );

  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_errs   = 0;
  xact_t log_q[$];
  bit    rand_wait = 0;
  bit    stray     = 0;
  int    wait_left = -1;
  int    hold_err  = 0;
  bit    prev_wait = 0;
  logic [31:0] prev_addr;
  bit    prev_st;
  bit    resp_req;
  int    pulse_total = 0;
  int    busy_cnt;
  bit    pulse_ld, pulse_st;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    return (w * 32'd2654435761) ^ 32'h5A3C96E1;
  endfunction

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [31:0] wd;
    wd = mem_word(a) >> {a[1:0], 3'b000};
    return wd[7:0];
  endfunction

  // Memory model: decides mem_ack for the coming edge on each falling edge.
  always @(negedge clk) begin
    resp_req = mem_if.ld_req | mem_if.st_req;
    if (prev_wait && (!resp_req || mem_if.lsu2mem_addr != prev_addr || mem_if.st_req != prev_st))
      hold_err++;
    if (resp_req) begin
      if (wait_left < 0) wait_left = rand_wait ? int'($urandom_range(0, 3)) : 0;
      if (wait_left == 0) begin
        mem_if.mem_ack      = 1'b1;
        mem_if.mem2lsu_data = mem_word(mem_if.lsu2mem_addr);
        wait_left           = -1;
        log_q.push_back('{mem_if.st_req, mem_if.lsu2mem_addr, mem_if.lsu2mem_data, mem_if.lsu2mem_wmask});
      end else begin
        mem_if.mem_ack      = 1'b0;
        mem_if.mem2lsu_data = 32'hDEAD_BEEF;
        wait_left--;
      end
    end else begin
      mem_if.mem_ack      = stray;
      mem_if.mem2lsu_data = 32'hDEAD_BEEF;
      wait_left           = -1;
    end
    prev_wait = resp_req && !mem_if.mem_ack;
    prev_addr = mem_if.lsu2mem_addr;
    prev_st   = mem_if.st_req;
  end

  always @(negedge clk) if (is_loaded || is_stored) pulse_total++;

  // Starts one instruction and waits (bounded) for its completion pulse.
  // lat is the cycle of the pulse counted from the start edge t (t+lat).
  task automatic run(input bit ld, input bit st, input logic [31:0] base,
                     input logic [31:0] stride, input logic [9:0] vl,
                     input logic [6:0] s, input bit unit, input int inj_k,
                     output int lat);
    log_q.delete();
    @(negedge clk);
    rs1_data = base; rs2_data = stride; vlmax = vl; sew = s; stride_sel = unit;
    ld_inst = ld; st_inst = st;
    @(negedge clk);
    ld_inst = 0; st_inst = 0;
    lat = -1; busy_cnt = 0; pulse_ld = 0; pulse_st = 0;
    for (int k = 1; k <= 3000; k++) begin
      st_inst = (k == inj_k);
      if (busy) busy_cnt++;
      if (is_loaded || is_stored) begin
        lat = k; pulse_ld = is_loaded; pulse_st = is_stored;
        break;
      end
      @(negedge clk);
    end
    st_inst = 0;
    check("completion_seen", lat > 0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, n_st, p0;
    logic [31:0] a;
    n_rst = 1; ld_inst = 0; st_inst = 0; rs1_data = 0; rs2_data = 0;
    vlmax = 0; sew = 32; stride_sel = 1; vs3_data = '0;
    mem_if.mem_ack = 0; mem_if.mem2lsu_data = 0;
    #1 n_rst = 0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_req",   {mem_if.ld_req, mem_if.st_req}, 0);
    check("rst_addr",  mem_if.lsu2mem_addr, 0);
    check("rst_wdata", {mem_if.lsu2mem_wmask, mem_if.lsu2mem_data}, 0);
    check("rst_vd",    |vd_data, 0);
    check("rst_flags", {is_loaded, is_stored, busy, lsu_err}, 0);
    n_rst = 1;
    @(negedge clk);

    // Stray ack while idle is ignored
    stray = 1;
    repeat (3) @(negedge clk);
    check("stray_idle", {busy, mem_if.ld_req, mem_if.st_req}, 0);
    check("stray_log",  log_q.size(), 0);
    stray = 0;

    // T1: unit-stride load, sew=32, zero wait
    run(1, 0, 32'h400, 0, 16, 32, 1, 0, lat);
    check("t1_lat",  lat, 17);
    check("t1_busy", busy_cnt, 17);
    check("t1_kind", {pulse_ld, pulse_st}, 2'b10);
    check("t1_n",    log_q.size(), 16);
    for (int i = 0; i < 16 && i < log_q.size(); i++) begin
      check($sformatf("t1_addr%0d", i), log_q[i].addr, 32'h400 + 4 * i);
      check($sformatf("t1_vd%0d", i), vd_data[i*32 +: 32], mem_word(32'h400 + 4 * i));
    end
    check("t1_tail", |vd_data[MAX_VLEN-1:512], 0);
    check("t1_err",  lsu_err, 0);

    // T2: constant stride 12 with random wait states
    rand_wait = 1;
    run(1, 0, 32'h400, 12, 16, 32, 0, 0, lat);
    rand_wait = 0;
    check("t2_lat_range", (lat >= 17) && (lat <= 65), 1);
    check("t2_n",    log_q.size(), 16);
    for (int i = 0; i < 16 && i < log_q.size(); i++) begin
      check($sformatf("t2_addr%0d", i), log_q[i].addr, 32'h400 + 12 * i);
      check($sformatf("t2_vd%0d", i), vd_data[i*32 +: 32], mem_word(32'h400 + 12 * i));
    end
    check("t2_hold", hold_err, 0);

    // T3: byte lanes, sew=8 from an odd base
    run(1, 0, 32'h201, 0, 64, 8, 1, 0, lat);
    check("t3_lat", lat, 65);
    check("t3_n",   log_q.size(), 64);
    for (int i = 0; i < 64 && i < log_q.size(); i++) begin
      a = 32'h201 + i;
      check($sformatf("t3_addr%0d", i), log_q[i].addr, {a[31:2], 2'b00});
      check($sformatf("t3_vd%0d", i), vd_data[i*8 +: 8], mem_byte(a));
    end
    check("t3_tail", |vd_data[MAX_VLEN-1:512], 0);

    // T4: halfword store, base 0x302 -> alternating lanes
    vs3_data = '0;
    vs3_data[63:0] = 64'hDDD4_CCC3_BBB2_AAA1;
    run(0, 1, 32'h302, 0, 4, 16, 1, 0, lat);
    check("t4_lat",  lat, 5);
    check("t4_kind", {pulse_ld, pulse_st}, 2'b01);
    check("t4_n",    log_q.size(), 4);
    if (log_q.size() == 4) begin
      check("t4_st0", {log_q[0].is_st, log_q[0].addr, log_q[0].mask, log_q[0].data}, {1'b1, 32'h300, 4'b1100, 32'hAAA1_0000});
      check("t4_st1", {log_q[1].is_st, log_q[1].addr, log_q[1].mask, log_q[1].data}, {1'b1, 32'h304, 4'b0011, 32'h0000_BBB2});
      check("t4_st2", {log_q[2].is_st, log_q[2].addr, log_q[2].mask, log_q[2].data}, {1'b1, 32'h304, 4'b1100, 32'hCCC3_0000});
      check("t4_st3", {log_q[3].is_st, log_q[3].addr, log_q[3].mask, log_q[3].data}, {1'b1, 32'h308, 4'b0011, 32'h0000_DDD4});
    end
    check("t4_vd_kept", vd_data[7:0], mem_byte(32'h201));

    // T5: misaligned second element, then vlmax=0, then illegal sew
    run(1, 0, 32'h400, 6, 4, 32, 0, 0, lat);
    check("t5_lat",  lat, 2);
    check("t5_kind", {pulse_ld, pulse_st}, 2'b10);
    check("t5_n",    log_q.size(), 1);
    check("t5_err",  lsu_err, 1);
    check("t5_el0",  vd_data[31:0], mem_word(32'h400));
    check("t5_el1",  vd_data[63:32], 0);
    @(negedge clk);
    check("t5_sticky", lsu_err, 1);
    run(1, 0, 32'h400, 4, 0, 32, 1, 0, lat);
    check("t5_n0_lat", lat, 1);
    check("t5_n0_log", log_q.size(), 0);
    check("t5_n0_err", lsu_err, 0);
    run(1, 0, 32'h400, 0, 3, 24, 1, 0, lat);
    check("t5_sew_lat", lat, 1);
    check("t5_sew_log", log_q.size(), 0);
    check("t5_sew_err", lsu_err, 1);

    // T6: simultaneous starts -> load only; store start while busy ignored
    run(1, 1, 32'h500, 0, 2, 32, 1, 0, lat);
    n_st = 0;
    foreach (log_q[i]) if (log_q[i].is_st) n_st++;
    check("t6_kind", {pulse_ld, pulse_st}, 2'b10);
    check("t6_lat",  lat, 3);
    check("t6_nst",  n_st, 0);
    run(1, 0, 32'h540, 0, 8, 32, 1, 2, lat);
    n_st = 0;
    foreach (log_q[i]) if (log_q[i].is_st) n_st++;
    check("t6b_lat", lat, 9);
    check("t6b_nst", n_st, 0);
    repeat (3) @(negedge clk);
    check("t6b_idle", {busy, mem_if.ld_req, mem_if.st_req}, 0);

    // T7: asynchronous reset mid-load, then a clean load
    log_q.delete();
    @(negedge clk);
    rs1_data = 32'h600; rs2_data = 0; vlmax = 16; sew = 32; stride_sel = 1; ld_inst = 1;
    @(negedge clk);
    ld_inst = 0;
    for (int k = 0; k < 100; k++) begin
      if (log_q.size() >= 5) break;
      @(negedge clk);
    end
    check("t7_progress", log_q.size() >= 5, 1);
    p0 = pulse_total;
    #2 n_rst = 0;
    #1;
    check("t7_rst_req",   {mem_if.ld_req, mem_if.st_req, busy, is_loaded, lsu_err}, 0);
    check("t7_rst_addr",  mem_if.lsu2mem_addr, 0);
    check("t7_rst_vd",    |vd_data, 0);
    repeat (3) @(negedge clk);
    n_rst = 1;
    repeat (2) @(negedge clk);
    check("t7_no_pulse", pulse_total, p0);
    run(1, 0, 32'h600, 0, 4, 32, 1, 0, lat);
    check("t7_lat", lat, 5);
    check("t7_n",   log_q.size(), 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("t7_vd%0d", i), vd_data[i*32 +: 32], mem_word(32'h600 + 4 * i));

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
